// File: rtl/pic_inta_sequencer.sv
// -----------------------------------------------------------------------------
// pic_inta_sequencer
// INTA-cycle controller of the 8259A core. Raises INT to the CPU, counts INTA
// pulses, latches the winning IR and sequences the data bus buffer (CALL
// opcode, vector byte, address byte). Issues ISR-set and auto-EOI strobes.
//
// Optional feature macro: INTA_TIMEOUT_EN
//   defined   : a WAIT2/WAIT3 watchdog aborts the sequence after
//               TIMEOUT_CYCLES clocks and pulses timeout_err.
//   undefined : WAIT states hold indefinitely, timeout_err tied 0.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   inta_n       in   CPU interrupt acknowledge (async, active low)
//   int_req      in   priority resolver request (level)
//   irq_id[2:0]  in   winning IR number, valid while int_req=1
//   mode_8086    in   1 = 8086 (2 INTA), 0 = 8080/85 (3 INTA)
//   adi          in   8080 call interval: 1 = 4 bytes, 0 = 8 bytes
//   vec_base[7:0]in   vector base (T7..T3 / A7..A5)
//   addr_hi[7:0] in   8080 third byte (A15..A8)
//   aeoi         in   auto-EOI enable
//   int_out      out  INT pin to CPU
//   bus_en       out  data bus buffer enable
//   bus_dir      out  1 = drive dout to CPU
//   dout[7:0]    out  byte presented to the buffer
//   freeze       out  holds IRR/priority stable during the sequence
//   isr_set      out  1-cycle strobe: set ISR bit isr_id
//   isr_id[2:0]  out  latched IR number
//   eoi_auto     out  1-cycle strobe: clear ISR bit isr_id
//   busy         out  sequence in progress
//   timeout_err  out  1-cycle strobe on INTA timeout
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no sequence, int_out follows int_req
// ACK1  | first INTA low: 8080 drives CALL, 8086 keeps bus off
// WAIT2 | between first and second INTA
// ACK2  | second INTA low: vector / low address byte driven
// WAIT3 | 8080 only, between second and third INTA
// ACK3  | 8080 only, third INTA low: high address byte driven
// -----------------------------------------------------------------------------
module pic_inta_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inta_n,
  input  logic       int_req,
  input  logic [2:0] irq_id,
  input  logic       mode_8086,
  input  logic       adi,
  input  logic [7:0] vec_base,
  input  logic [7:0] addr_hi,
  input  logic       aeoi,
  output logic       int_out,
  output logic       bus_en,
  output logic       bus_dir,
  output logic [7:0] dout,
  output logic       freeze,
  output logic       isr_set,
  output logic [2:0] isr_id,
  output logic       eoi_auto,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK1  = 3'd1,
    WAIT2 = 3'd2,
    ACK2  = 3'd3,
    WAIT3 = 3'd4,
    ACK3  = 3'd5
  } state_t;

  state_t state;

  // inta_n synchronizer plus one extra flop for edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   fall;
  logic                   rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      sync_prev <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], inta_n};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall = sync_prev & ~sync_q[SYNC_STAGES-1];
  assign rise = ~sync_prev & sync_q[SYNC_STAGES-1];

  // Configuration captured at the first INTA so mid-sequence ICW writes
  // cannot corrupt the bytes being driven.
  logic       m8086_q;
  logic       adi_q;
  logic [7:0] vec_q;
  logic [7:0] addr_q;
  logic       aeoi_q;
  logic       spur_q;

  logic [7:0] vec_byte;

  always_comb begin
    vec_byte = 8'h00;
    if (m8086_q)
      vec_byte = {vec_q[7:3], isr_id};
    else if (adi_q)
      vec_byte = {vec_q[7:5], isr_id, 2'b00};
    else
      vec_byte = {vec_q[7:6], isr_id, 3'b000};
  end

  assign busy = (state != IDLE);

`ifdef INTA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      int_out  <= 1'b0;
      bus_en   <= 1'b0;
      bus_dir  <= 1'b0;
      dout     <= 8'h00;
      freeze   <= 1'b0;
      isr_set  <= 1'b0;
      isr_id   <= 3'd0;
      eoi_auto <= 1'b0;
      m8086_q  <= 1'b0;
      adi_q    <= 1'b0;
      vec_q    <= 8'h00;
      addr_q   <= 8'h00;
      aeoi_q   <= 1'b0;
      spur_q   <= 1'b0;
`ifdef INTA_TIMEOUT_EN
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      isr_set  <= 1'b0;
      eoi_auto <= 1'b0;
      int_out  <= 1'b0;
`ifdef INTA_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          int_out <= int_req & ~fall;
          if (fall) begin
            state   <= ACK1;
            m8086_q <= mode_8086;
            adi_q   <= adi;
            vec_q   <= vec_base;
            addr_q  <= addr_hi;
            aeoi_q  <= aeoi;
            freeze  <= 1'b1;
            if (int_req) begin
              isr_id  <= irq_id;
              isr_set <= 1'b1;
              spur_q  <= 1'b0;
            end else begin
              // spurious acknowledge reports IR7 and touches no ISR bit
              isr_id  <= 3'd7;
              spur_q  <= 1'b1;
            end
            if (mode_8086) begin
              bus_en <= 1'b0;
            end else begin
              bus_en  <= 1'b1;
              bus_dir <= 1'b1;
              dout    <= 8'hCD;
            end
          end
        end

        ACK1: begin
          if (rise) begin
            state  <= WAIT2;
            bus_en <= 1'b0;
`ifdef INTA_TIMEOUT_EN
            tmo_cnt <= CW'(TIMEOUT_CYCLES);
`endif
          end
        end

        WAIT2: begin
          if (fall) begin
            state   <= ACK2;
            bus_en  <= 1'b1;
            bus_dir <= 1'b1;
            dout    <= vec_byte;
          end
`ifdef INTA_TIMEOUT_EN
          else if (tmo_cnt <= CW'(1)) begin
            state       <= IDLE;
            freeze      <= 1'b0;
            bus_en      <= 1'b0;
            bus_dir     <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - CW'(1);
          end
`endif
        end

        ACK2: begin
          if (rise) begin
            if (m8086_q) begin
              state    <= IDLE;
              bus_en   <= 1'b0;
              bus_dir  <= 1'b0;
              dout     <= 8'h00;
              freeze   <= 1'b0;
              eoi_auto <= aeoi_q & ~spur_q;
            end else begin
              state  <= WAIT3;
              bus_en <= 1'b0;
`ifdef INTA_TIMEOUT_EN
              tmo_cnt <= CW'(TIMEOUT_CYCLES);
`endif
            end
          end
        end

        WAIT3: begin
          if (fall) begin
            state   <= ACK3;
            bus_en  <= 1'b1;
            bus_dir <= 1'b1;
            dout    <= addr_q;
          end
`ifdef INTA_TIMEOUT_EN
          else if (tmo_cnt <= CW'(1)) begin
            state       <= IDLE;
            freeze      <= 1'b0;
            bus_en      <= 1'b0;
            bus_dir     <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - CW'(1);
          end
`endif
        end

        ACK3: begin
          if (rise) begin
            state    <= IDLE;
            bus_en   <= 1'b0;
            bus_dir  <= 1'b0;
            dout     <= 8'h00;
            freeze   <= 1'b0;
            eoi_auto <= aeoi_q & ~spur_q;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifndef INTA_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule
